// File: rtl/csr_packer.sv
// Dense-to-CSR encoder: takes a 16x16 int8 matrix one row per handshake, compacts the
// nonzeros into value/column/rowptr storage, then streams the CSR image as 32-bit words.
module csr_packer #(
    parameter int N       = 16,
    parameter int MAX_NNZ = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic             row_valid_i,
    output logic             row_ready_o,
    input  logic [8*N-1:0]   row_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic             out_last_o,
    output logic [7:0]       nnz_count_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int VAL_WORDS = MAX_NNZ / 4;
    localparam int IDX_WORDS = MAX_NNZ / 8;
    localparam int RP_WORDS  = (N + 4) / 4;
    localparam int NUM_WORDS = VAL_WORDS + IDX_WORDS + RP_WORDS;
    localparam int WW        = $clog2(NUM_WORDS);
    localparam logic [WW-1:0] LAST_WORD = WW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                row_cnt_q, row_cnt_d;
    logic [WW-1:0]             widx_q, widx_d;
    logic [7:0]                nnz_q, nnz_d;
    logic                      ovf_q, ovf_d;
    logic [8*MAX_NNZ-1:0]      vals_q, vals_d;
    logic [4*MAX_NNZ-1:0]      cols_q, cols_d;
    // Rowptr storage is padded to whole words; the padding bytes are never written.
    logic [32*RP_WORDS-1:0]    rowptr_q, rowptr_d;
    logic [N-1:0]              col_nz;
    logic [31:0]               word_sel;

    for (genvar gi = 0; gi < N; gi++) begin : g_nz
        assign col_nz[gi] = |row_data_i[8*gi +: 8];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            row_cnt_q <= '0;
            widx_q    <= '0;
            nnz_q     <= '0;
            ovf_q     <= 1'b0;
            vals_q    <= '0;
            cols_q    <= '0;
            rowptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            widx_q    <= widx_d;
            nnz_q     <= nnz_d;
            ovf_q     <= ovf_d;
            vals_q    <= vals_d;
            cols_q    <= cols_d;
            rowptr_q  <= rowptr_d;
        end
    end

    always_comb begin
        int slot;
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        widx_d    = widx_q;
        nnz_d     = nnz_q;
        ovf_d     = ovf_q;
        vals_d    = vals_q;
        cols_d    = cols_q;
        rowptr_d  = rowptr_q;
        slot      = int'(nnz_q);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_COLLECT;
                    row_cnt_d = '0;
                    widx_d    = '0;
                    nnz_d     = '0;
                    ovf_d     = 1'b0;
                    vals_d    = '0;
                    cols_d    = '0;
                    rowptr_d  = '0;
                end
            end
            S_COLLECT: begin
                if (row_valid_i) begin
                    // Running slot acts as nnz_count + prefix count of earlier nonzero columns.
                    for (int j = 0; j < N; j++) begin
                        if (col_nz[j]) begin
                            if (slot < MAX_NNZ) begin
                                vals_d[8*slot +: 8] = row_data_i[8*j +: 8];
                                cols_d[4*slot +: 4] = 4'(j);
                            end else begin
                                ovf_d = 1'b1;
                            end
                            slot = slot + 1;
                        end
                    end
                    nnz_d = (slot > MAX_NNZ) ? 8'(MAX_NNZ) : 8'(slot);
                    rowptr_d[8*(int'(row_cnt_q) + 1) +: 8] = nnz_d;
                    row_cnt_d = row_cnt_q + 4'd1;
                    if (row_cnt_q == 4'd15) begin
                        state_d = S_EMIT;
                        widx_d  = '0;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready_i) begin
                    if (widx_q == LAST_WORD) begin
                        state_d = S_DONE;
                    end else begin
                        widx_d = widx_q + WW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output word is selected purely from registered storage by the registered index.
    always_comb begin
        int w;
        w        = int'(widx_q);
        word_sel = '0;
        if (w < VAL_WORDS) begin
            word_sel = vals_q[32*w +: 32];
        end else if (w < VAL_WORDS + IDX_WORDS) begin
            word_sel = cols_q[32*(w - VAL_WORDS) +: 32];
        end else if (w < NUM_WORDS) begin
            word_sel = rowptr_q[32*(w - VAL_WORDS - IDX_WORDS) +: 32];
        end
    end

    assign row_ready_o = (state_q == S_COLLECT);
    assign out_valid_o = (state_q == S_EMIT);
    assign out_data_o  = out_valid_o ? word_sel : 32'h0;
    assign out_last_o  = out_valid_o && (widx_q == LAST_WORD);
    assign nnz_count_o = nnz_q;
    assign overflow_o  = ovf_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_csr_packer.sv
// Directed bench for csr_packer: table of whole-matrix jobs with hand-computed words,
// plus a mid-EMIT reset sequence followed by a fresh job.
module tb_csr_packer;
    logic         clk = 1'b0;
    logic         rstn;
    logic         start_i;
    logic         row_valid_i;
    logic         row_ready_o;
    logic [127:0] row_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [31:0]  out_data_o;
    logic         out_last_o;
    logic [7:0]   nnz_count_o;
    logic         overflow_o;
    logic         busy_o;
    logic         done_o;

    csr_packer dut (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (start_i),
        .row_valid_i (row_valid_i),
        .row_ready_o (row_ready_o),
        .row_data_i  (row_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .nnz_count_o (nnz_count_o),
        .overflow_o  (overflow_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pat;
        bit          rnd;
        bit          glitch;
        logic [7:0]  nnz;
        logic        ovf;
        logic [31:0] w0, w1, w16, w17, w24, w28;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mat [16][16];
    logic [31:0] exp_w [29];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end else begin
            $display("ok   %s: %08h", name, got);
        end
    endtask

    task automatic build_matrix(input int pat);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                case (pat)
                    0:       mat[r][c] = (r == c) ? 8'h01 : 8'h00;
                    1:       mat[r][c] = 8'h00;
                    2:       mat[r][c] = 8'hFF;
                    default: mat[r][c] = (c == 15 - r) ? 8'h80 : 8'h00;
                endcase
            end
        end
        if (pat == 3) mat[5][0] = 8'h7F;
    endtask

    // Reference CSR image built straight from the dense matrix.
    task automatic build_model();
        logic [7:0] v [64];
        logic [3:0] c [64];
        logic [7:0] rp [17];
        int k = 0;
        for (int i = 0; i < 64; i++) begin v[i] = 8'h00; c[i] = 4'h0; end
        rp[0] = 8'h00;
        for (int r = 0; r < 16; r++) begin
            for (int cc = 0; cc < 16; cc++) begin
                if (mat[r][cc] != 8'h00) begin
                    if (k < 64) begin
                        v[k] = mat[r][cc];
                        c[k] = 4'(cc);
                    end
                    k++;
                end
            end
            rp[r+1] = (k > 64) ? 8'd64 : 8'(k);
        end
        for (int i = 0; i < 29; i++) exp_w[i] = 32'h0;
        for (int i = 0; i < 64; i++) begin
            exp_w[i/4][8*(i%4) +: 8]       = v[i];
            exp_w[16 + i/8][4*(i%8) +: 4]  = c[i];
        end
        for (int i = 0; i < 17; i++) exp_w[24 + i/4][8*(i%4) +: 8] = rp[i];
    endtask

    function automatic logic [127:0] row_vec(input int r);
        logic [127:0] x;
        for (int c = 0; c < 16; c++) x[8*c +: 8] = mat[r][c];
        return x;
    endfunction

    task automatic run_job(input vec_t v, input int abort_at, input string tag);
        logic [31:0] got [29];
        logic [31:0] od, prev_data;
        logic        ol, prev_last, ov, rr, rdy;
        int          r, n, cyc, last_cnt, last_idx, mism;
        bit          stable_ok, prev_stall;

        build_matrix(v.pat);
        build_model();
        for (int i = 0; i < 29; i++) got[i] = 32'hDEADBEEF;

        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy_o), 32'd1);

        r = 0; cyc = 0;
        while (r < 16 && cyc < 400) begin
            rr          = row_ready_o;
            row_valid_i = v.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            row_data_i  = row_vec(r);
            start_i     = v.glitch ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(posedge clk); #1;
            if (row_valid_i && rr) r++;
            cyc++;
        end
        row_valid_i = 1'b0;
        start_i     = 1'b0;
        if (r < 16) begin
            check({tag, " collect_timeout"}, 32'(r), 32'd16);
            return;
        end
        check({tag, " latency_out_valid"}, 32'(out_valid_o), 32'd1);
        check({tag, " latency_word0"}, out_data_o, v.w0);

        n = 0; cyc = 0; last_cnt = 0; last_idx = -1;
        stable_ok = 1'b1; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        while (n < 29 && cyc < 1000) begin
            if (abort_at == n) begin
                rstn = 1'b0;
                @(posedge clk); #1;
                check({tag, " abort_out_valid"}, 32'(out_valid_o), 32'd0);
                check({tag, " abort_out_data"}, out_data_o, 32'd0);
                check({tag, " abort_busy"}, 32'(busy_o), 32'd0);
                check({tag, " abort_nnz"}, 32'(nnz_count_o), 32'd0);
                rstn        = 1'b1;
                out_ready_i = 1'b0;
                return;
            end
            ov = out_valid_o; od = out_data_o; ol = out_last_o;
            if (prev_stall && (od !== prev_data || ol !== prev_last)) stable_ok = 1'b0;
            rdy         = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready_i = rdy;
            start_i     = v.glitch ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(posedge clk); #1;
            prev_stall = ov && !rdy;
            prev_data  = od;
            prev_last  = ol;
            if (ov && rdy) begin
                got[n] = od;
                if (ol) begin last_cnt++; last_idx = n; end
                n++;
            end
            cyc++;
        end
        out_ready_i = 1'b0;
        start_i     = 1'b0;

        check({tag, " handshakes"}, 32'(n), 32'd29);
        check({tag, " done_pulse"}, 32'(done_o), 32'd1);
        check({tag, " nnz"}, 32'(nnz_count_o), 32'(v.nnz));
        check({tag, " overflow"}, 32'(overflow_o), 32'(v.ovf));
        check({tag, " last_count"}, 32'(last_cnt), 32'd1);
        check({tag, " last_index"}, 32'(last_idx), 32'd28);
        check({tag, " w0"}, got[0], v.w0);
        check({tag, " w1"}, got[1], v.w1);
        check({tag, " w16"}, got[16], v.w16);
        check({tag, " w17"}, got[17], v.w17);
        check({tag, " w24"}, got[24], v.w24);
        check({tag, " w28"}, got[28], v.w28);
        mism = 0;
        for (int i = 0; i < 29; i++) if (got[i] !== exp_w[i]) mism++;
        check({tag, " words_vs_model_mismatches"}, 32'(mism), 32'd0);
        if (v.rnd) check({tag, " stable_under_stall"}, 32'(stable_ok), 32'd1);

        @(posedge clk); #1;
        check({tag, " done_cleared"}, 32'(done_o), 32'd0);
        check({tag, " idle_not_busy"}, 32'(busy_o), 32'd0);
        check({tag, " nnz_holds"}, 32'(nnz_count_o), 32'(v.nnz));
    endtask

    vec_t vecs [5];
    vec_t vx;

    initial begin
        vecs[0] = '{0, 1'b0, 1'b0, 8'd16, 1'b0, 32'h01010101, 32'h01010101,
                    32'h76543210, 32'hFEDCBA98, 32'h03020100, 32'h00000010};
        vecs[1] = '{2, 1'b0, 1'b0, 8'd64, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'h76543210, 32'hFEDCBA98, 32'h30201000, 32'h00000040};
        vecs[2] = '{1, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0};
        vecs[3] = '{3, 1'b1, 1'b1, 8'd17, 1'b0, 32'h80808080, 32'h80807F80,
                    32'h9A0BCDEF, 32'h12345678, 32'h03020100, 32'h00000011};
        vecs[4] = '{2, 1'b1, 1'b1, 8'd64, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'h76543210, 32'hFEDCBA98, 32'h30201000, 32'h00000040};

        rstn = 1'b0; start_i = 1'b0; row_valid_i = 1'b0; row_data_i = '0; out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset row_ready", 32'(row_ready_o), 32'd0);
        check("reset out_valid", 32'(out_valid_o), 32'd0);
        check("reset out_data", out_data_o, 32'd0);
        check("reset out_last", 32'(out_last_o), 32'd0);
        check("reset nnz", 32'(nnz_count_o), 32'd0);
        check("reset overflow", 32'(overflow_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_job(vecs[i], -1, $sformatf("job%0d", i));

        // Reset during EMIT at word 10, then a fresh job must come out whole.
        run_job(vecs[0], 10, "abort");
        @(posedge clk); #1;
        vx = vecs[3];
        vx.rnd = 1'b0;
        vx.glitch = 1'b0;
        run_job(vx, -1, "fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
